// File: rtl/present_decrypt_pkg.sv
// Shared definitions for the PRESENT-80 decryptor: S-box tables, FSM state
// encoding, P-layer index helpers and the forward/inverse key-schedule steps.
package present_decrypt_pkg;

  localparam int ROUNDS_DEF = 31;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_KEY_EXP = 3'd1,
    ST_WHITEN  = 3'd2,
    ST_DEC     = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [3:0] INV_SBOX [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  // Forward P-layer: bit i moves to 16*i mod 63, bit 63 stays put.
  function automatic logic [5:0] p_idx(input logic [5:0] i);
    int ii;
    ii = int'(i);
    return (ii == 63) ? 6'd63 : 6'((16 * ii) % 63);
  endfunction

  // Inverse P-layer index: 4 is the inverse of 16 modulo 63.
  function automatic logic [5:0] inv_p_idx(input logic [5:0] j);
    int jj;
    jj = int'(j);
    return (jj == 63) ? 6'd63 : 6'((4 * jj) % 63);
  endfunction

  // Undo the P-layer: the bit that P moved to p_idx(i) is returned to i.
  function automatic logic [63:0] inv_p_layer(input logic [63:0] s);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) begin
      r[i] = s[p_idx(6'(i))];
    end
    return r;
  endfunction

  // Apply the inverse S-box to all sixteen nibbles.
  function automatic logic [63:0] inv_s_layer(input logic [63:0] s);
    logic [63:0] r;
    for (int n = 0; n < 16; n++) begin
      r[4*n +: 4] = INV_SBOX[s[4*n +: 4]];
    end
    return r;
  endfunction

  // One forward key-schedule step: rotate left 61, S-box top nibble, mix rc.
  function automatic logic [79:0] key_update_fwd(input logic [79:0] k,
                                                 input logic [4:0]  rc);
    logic [79:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = SBOX[r[79:76]];
    r[19:15]   = r[19:15] ^ rc;
    return r;
  endfunction

  // Exact inverse of key_update_fwd for the same rc.
  function automatic logic [79:0] key_update_inv(input logic [79:0] k,
                                                 input logic [4:0]  rc);
    logic [79:0] r;
    r          = k;
    r[19:15]   = r[19:15] ^ rc;
    r[79:76]   = INV_SBOX[r[79:76]];
    return {r[60:0], r[79:61]};
  endfunction

endpackage

// File: rtl/present_dec_round.sv
// One PRESENT-80 inverse round: steps the key schedule back by one round and
// peels one round off the cipher state using the recovered round key.
module present_dec_round
  import present_decrypt_pkg::*;
(
  input  logic [63:0] st_i,
  input  logic [79:0] key_i,
  input  logic [4:0]  rc_i,
  output logic [63:0] st_o,
  output logic [79:0] key_prev_o
);

  logic [79:0] key_prev;

  // Recover the previous round key, then undo P, undo S and add that key.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path
    // (here by unconditional first assignments) so no latch is inferred.
    key_prev   = key_update_inv(key_i, rc_i);
    st_o       = inv_s_layer(inv_p_layer(st_i)) ^ key_prev[79:16];
    key_prev_o = key_prev;
  end

endmodule

// File: rtl/present_decrypt.sv
// Iterative PRESENT-80 decryptor, one round per clock. The key schedule runs
// forward to K32, the state is whitened with K32, then inverse rounds run
// while the key schedule steps backwards.
// Optional build macro PRESENT_DEC_KEY_CACHE_EN keeps the last expanded K32
// with its source key so a repeated key skips the forward expansion.
module present_decrypt
  import present_decrypt_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEF
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] cipher_in,
  input  logic [79:0] key_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] plain_out,
  output logic        busy
);

  localparam logic [4:0] RC_LAST = 5'(ROUNDS);

  state_e      state_q;
  logic [63:0] st_q;
  logic [79:0] key_q;
  logic [4:0]  rc_q;
  logic [63:0] plain_q;
  logic        out_valid_q;
  logic        in_ready_q;
  logic        busy_q;

  logic [79:0] key_fwd_d;
  logic [63:0] st_dec_d;
  logic [79:0] key_prev_d;
  logic        accept;

  assign accept    = in_valid && in_ready_q;
  assign key_fwd_d = key_update_fwd(key_q, rc_q);

  present_dec_round u_round (
    .st_i       (st_q),
    .key_i      (key_q),
    .rc_i       (rc_q),
    .st_o       (st_dec_d),
    .key_prev_o (key_prev_d)
  );

`ifdef PRESENT_DEC_KEY_CACHE_EN
  logic        cache_vld_q;
  logic [79:0] cache_key_q;
  logic [79:0] cache_k32_q;
  logic        cache_hit;

  assign cache_hit = cache_vld_q && (key_in == cache_key_q);

  // Remember the source key on a miss and its K32 once expansion finishes.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      cache_vld_q <= 1'b0;
      cache_key_q <= '0;
      cache_k32_q <= '0;
    end else if (state_q == ST_IDLE && accept && !cache_hit) begin
      cache_key_q <= key_in;
      cache_vld_q <= 1'b0;
    end else if (state_q == ST_KEY_EXP && rc_q == RC_LAST) begin
      cache_k32_q <= key_fwd_d;
      cache_vld_q <= 1'b1;
    end
  end
`endif

  // Control FSM plus datapath registers; all outputs come straight from flops.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      // NOTE: every register, data included, is cleared so an aborted job
      // leaves no trace of the key or a partial plaintext behind.
      state_q     <= ST_IDLE;
      st_q        <= '0;
      key_q       <= '0;
      rc_q        <= '0;
      plain_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            st_q       <= cipher_in;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef PRESENT_DEC_KEY_CACHE_EN
            if (cache_hit) begin
              key_q   <= cache_k32_q;
              rc_q    <= RC_LAST;
              state_q <= ST_WHITEN;
            end else begin
              key_q   <= key_in;
              rc_q    <= 5'd1;
              state_q <= ST_KEY_EXP;
            end
`else
            key_q   <= key_in;
            rc_q    <= 5'd1;
            state_q <= ST_KEY_EXP;
`endif
          end
        end
        ST_KEY_EXP: begin
          key_q <= key_fwd_d;
          if (rc_q == RC_LAST) begin
            state_q <= ST_WHITEN;
          end else begin
            rc_q <= rc_q + 5'd1;
          end
        end
        ST_WHITEN: begin
          st_q    <= st_q ^ key_q[79:16];
          state_q <= ST_DEC;
        end
        ST_DEC: begin
          st_q  <= st_dec_d;
          key_q <= key_prev_d;
          rc_q  <= rc_q - 5'd1;
          if (rc_q == 5'd1) begin
            plain_q     <= st_dec_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign plain_out = plain_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_present_decrypt.sv
// Bench for present_decrypt: a bit-level PRESENT-80 model generates
// ciphertexts from random plaintexts, and a compare process checks every
// delivered result, the handshake signals and the job latency.
module tb_present_decrypt;

  localparam int ROUNDS = 31;
`ifdef PRESENT_DEC_KEY_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic        sys_clk;
  logic        sys_rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] cipher_in;
  logic [79:0] key_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] plain_out;
  logic        busy;

  present_decrypt dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cipher_in (cipher_in),
    .key_in    (key_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .plain_out (plain_out),
    .busy      (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_pass   = 0;

  bit [63:0] exp_q[$];
  bit        m_cvld = 1'b0;
  bit [79:0] m_ckey = '0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural PRESENT-80 model ----------------
  localparam bit [3:0] MS [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  function automatic bit [3:0] m_s(input bit [3:0] x);
    return MS[x];
  endfunction

  // Inverse S-box found by searching the forward table.
  function automatic bit [3:0] m_si(input bit [3:0] y);
    for (int x = 0; x < 16; x++) if (MS[x] == y) return 4'(x);
    return 4'h0;
  endfunction

  function automatic bit [63:0] m_p(input bit [63:0] s);
    bit [63:0] r;
    for (int i = 0; i < 63; i++) r[(16 * i) % 63] = s[i];
    r[63] = s[63];
    return r;
  endfunction

  function automatic bit [63:0] m_sl(input bit [63:0] s, input bit inv);
    bit [63:0] r;
    for (int n = 0; n < 16; n++) r[4*n +: 4] = inv ? m_si(s[4*n +: 4]) : m_s(s[4*n +: 4]);
    return r;
  endfunction

  function automatic bit [79:0] m_kupd(input bit [79:0] k, input int r);
    k        = {k[18:0], k[79:19]};
    k[79:76] = m_s(k[79:76]);
    k[19:15] = k[19:15] ^ 5'(r);
    return k;
  endfunction

  function automatic bit [63:0] m_encrypt(input bit [63:0] pt, input bit [79:0] key);
    bit [63:0] s;
    bit [79:0] k;
    s = pt;
    k = key;
    for (int r = 1; r <= ROUNDS; r++) begin
      s = m_p(m_sl(s ^ k[79:16], 1'b0));
      k = m_kupd(k, r);
    end
    return s ^ k[79:16];
  endfunction

  // P has order 3, so applying it twice is its inverse.
  function automatic bit [63:0] m_decrypt(input bit [63:0] ct, input bit [79:0] key);
    bit [63:0] rk [1:32];
    bit [79:0] k;
    bit [63:0] s;
    k = key;
    for (int r = 1; r <= 32; r++) begin
      rk[r] = k[79:16];
      if (r < 32) k = m_kupd(k, r);
    end
    s = ct ^ rk[32];
    for (int r = 31; r >= 1; r--) s = m_sl(m_p(m_p(s)), 1'b1) ^ rk[r];
    return s;
  endfunction

  function automatic int m_latency(input bit [79:0] key);
    return (CACHE_EN && m_cvld && m_ckey == key) ? ROUNDS + 1 : 2 * ROUNDS + 1;
  endfunction

  function automatic bit [79:0] rand_key();
    return {$urandom, $urandom, 16'($urandom)};
  endfunction

  // ---------------- compare process ----------------
  initial begin : compare
    forever begin
      @(negedge sys_clk);
      if (sys_rst === 1'b1) begin
        check("in_ready_vs_busy", in_ready, !busy);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL spurious_result: got %h, expected no result (t=%0t)", plain_out, $time);
          end else begin
            check("plain_out", plain_out, exp_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic accept_job(input bit [63:0] ct, input bit [79:0] key);
    int w;
    w = 0;
    cipher_in = ct;
    key_in    = key;
    in_valid  = 1'b1;
    while (!in_ready && w < 200) begin
      @(posedge sys_clk); #1;
      w++;
    end
    if (w >= 200) check("in_ready_timeout", w, 0);
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_job(input bit [63:0] ct, input bit [79:0] key, input bit [63:0] pt,
                         input int hold, input bit noise);
    int exp_lat;
    int cnt;
    exp_lat = m_latency(key);
    exp_q.push_back(pt);
    out_ready = (hold == 0);
    accept_job(ct, key);
    if (exp_lat != ROUNDS + 1) begin
      m_cvld = 1'b1;
      m_ckey = key;
    end
    cnt = 0;
    while (!out_valid && cnt < 200) begin
      if (noise) begin
        in_valid  = (cnt >= 4 && cnt < 9);
        cipher_in = {$urandom, $urandom};
        key_in    = ~key;
      end
      @(posedge sys_clk); #1;
      cnt++;
    end
    in_valid = 1'b0;
    check("latency", cnt, exp_lat);
    for (int i = 0; i < hold; i++) begin
      check("hold_out_valid", out_valid, 1'b1);
      check("hold_plain_out", plain_out, pt);
      check("hold_in_ready", in_ready, 1'b0);
      @(posedge sys_clk); #1;
    end
    out_ready = 1'b1;
    @(posedge sys_clk); #1;
    check("out_valid_drop", out_valid, 1'b0);
    check("in_ready_back", in_ready, 1'b1);
  endtask

  task automatic run_random(input bit [79:0] key, input bit noise);
    bit [63:0] pt;
    pt = {$urandom, $urandom};
    run_job(m_encrypt(pt, key), key, pt, 0, noise);
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    bit [79:0] key_a;
    bit [79:0] key_b;
    bit [63:0] ct;
    int        lat;

    sys_rst   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cipher_in = '0;
    key_in    = '0;

    // Known vectors pin the model itself.
    check("model_v1", m_decrypt(64'h3333DCD3213210D2, {80{1'b1}}), 64'hFFFFFFFFFFFFFFFF);
    check("model_v2", m_decrypt(64'h5579C1387B228445, 80'h0), 64'h0);
    check("model_v3", m_decrypt(64'hA112FFC72F68417B, 80'h0), 64'hFFFFFFFFFFFFFFFF);
    check("model_v4", m_encrypt(64'h0, {80{1'b1}}), 64'hE72C46C0F5945049);

    repeat (3) @(posedge sys_clk);
    #2;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_plain_out", plain_out, 64'h0);
    check("rst_busy", busy, 1'b0);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;

    run_job(64'h3333DCD3213210D2, {80{1'b1}}, 64'hFFFFFFFFFFFFFFFF, 0, 1'b0);
    run_job(64'h5579C1387B228445, 80'h0, 64'h0, 0, 1'b0);
    run_job(64'hA112FFC72F68417B, 80'h0, 64'hFFFFFFFFFFFFFFFF, 0, 1'b0);
    run_job(64'hE72C46C0F5945049, {80{1'b1}}, 64'h0, 10, 1'b0);

    // in_valid pulsed while busy must not start a second job.
    run_random(rand_key(), 1'b1);

    // Cache-style sequence: same key twice, then a different key.
    key_a = rand_key();
    key_b = rand_key();
    run_random(key_a, 1'b0);
    run_random(key_a, 1'b0);
    run_random(key_b, 1'b0);

    // Reset in the middle of the inverse rounds.
    key_a = rand_key();
    ct    = {$urandom, $urandom};
    lat   = m_latency(key_a);
    out_ready = 1'b1;
    accept_job(ct, key_a);
    repeat (lat - 11) @(posedge sys_clk);
    #2;
    check("pre_rst_busy", busy, 1'b1);
    check("pre_rst_out_valid", out_valid, 1'b0);
    sys_rst = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_plain_out", plain_out, 64'h0);
    check("abort_busy", busy, 1'b0);
    m_cvld = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    run_random(key_a, 1'b0);

    // Random jobs, frequently reusing the previous key.
    key_b = rand_key();
    for (int j = 0; j < 12; j++) begin
      if ($urandom_range(0, 1) == 0) key_b = rand_key();
      run_random(key_b, 1'b0);
    end

    repeat (3) @(posedge sys_clk);
    check("results_outstanding", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
